// File: rtl/rtc_trigger_ctrl_if.sv
// Button inputs and rtc_counter control outputs of the stopwatch trigger front end.
// The master side presses the buttons and watches the controls; the slave side is the controller.
interface rtc_trigger_ctrl_if;
    logic i_startstop;
    logic i_clear;
    logic o_countinit;
    logic o_countenb;
    logic o_latchcount;
    logic o_running;

    modport master (
        output i_startstop,
        output i_clear,
        input  o_countinit,
        input  o_countenb,
        input  o_latchcount,
        input  o_running
    );

    modport slave (
        input  i_startstop,
        input  i_clear,
        output o_countinit,
        output o_countenb,
        output o_latchcount,
        output o_running
    );
endinterface

// File: rtl/rtc_trigger_ctrl.sv
// Stopwatch trigger front end: per-button 2-flop sync plus debounce, then the
// run/pause/clear FSM producing registered rtc_counter controls.

module rtc_trigger_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_rtcclk,
    input  logic i_reset_n,
    input  logic i_raw,
    output logic o_level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_rtcclk) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept on the cycle the count would reach DEBOUNCE_CYCLES; any agreeing
    // sample in between throws the partial count away.
    always_ff @(posedge i_rtcclk) begin
        if (!i_reset_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_level = r_level;
endmodule

module rtc_trigger_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic               i_rtcclk,
    input logic               i_reset_n,
    rtc_trigger_ctrl_if.slave bus
);
    localparam int NUM_BTN = 2;
    localparam int BTN_SS  = 0;
    localparam int BTN_CLR = 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_deb;
    logic [NUM_BTN-1:0] r_deb_d;
    logic [NUM_BTN-1:0] w_evt;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_pulse;
    logic       r_countinit;
    logic       r_countenb;
    logic       r_latchcount;
    logic       r_running;

    assign w_raw = {bus.i_clear, bus.i_startstop};

    rtc_trigger_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb [NUM_BTN-1:0] (
        .i_rtcclk (i_rtcclk),
        .i_reset_n(i_reset_n),
        .i_raw    (w_raw),
        .o_level  (w_deb)
    );

    // Press only: a held or released button yields nothing further.
    always_ff @(posedge i_rtcclk) begin
        if (!i_reset_n) r_deb_d <= '0;
        else            r_deb_d <= w_deb;
    end

    assign w_evt = w_deb & ~r_deb_d;

    always_comb begin
        w_state_nxt = r_state;
        w_pulse     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_evt[BTN_SS]) begin
                    w_state_nxt = ST_RUNNING;
                    w_pulse     = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (w_evt[BTN_SS]) begin
                    w_state_nxt = ST_PAUSED;
                    w_pulse     = 1'b1;
                end
            end
            ST_PAUSED: begin
                // Clear outranks start/stop only here, so a double press resets.
                if (w_evt[BTN_CLR]) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_evt[BTN_SS]) begin
                    w_state_nxt = ST_RUNNING;
                    w_pulse     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_rtcclk) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_countinit  <= 1'b1;
            r_countenb   <= 1'b0;
            r_latchcount <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_countinit  <= (w_state_nxt == ST_IDLE);
            r_countenb   <= w_pulse;
            r_latchcount <= w_pulse;
            r_running    <= (w_state_nxt == ST_RUNNING);
        end
    end

    assign bus.o_countinit  = r_countinit;
    assign bus.o_countenb   = r_countenb;
    assign bus.o_latchcount = r_latchcount;
    assign bus.o_running    = r_running;
endmodule

// File: tb/tb_rtc_trigger_ctrl.sv
// Directed cycle vectors for rtc_trigger_ctrl plus hand sequences for latency
// and held-button behaviour.
module tb_rtc_trigger_ctrl;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rtc_trigger_ctrl_if bus();

    rtc_trigger_ctrl #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .i_rtcclk (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst_n;
        logic ss;
        logic clr;
        logic init;
        logic enb;
        logic run;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic s, input logic c,
                       input logic i, input logic e, input logic u, input int n);
        vec_t v;
        v.rst_n = r; v.ss = s; v.clr = c;
        v.init = i; v.enb = e; v.run = u;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int lat;
        int got;
        int pulses;
        int latches;
        int not_run;

        bus.i_startstop = 1'b0;
        bus.i_clear     = 1'b0;

        // rst_n, ss, clr | countinit, countenb(=latchcount), running
        // Reset with both buttons held; start wins over clear at edge 7 after release.
        add(0,1,1, 1,0,0, 2);
        add(1,1,1, 1,0,0, 6);
        add(1,1,1, 0,1,1, 1);
        add(1,1,1, 0,0,1, 3);
        add(1,0,0, 0,0,1, 8);
        // Back to IDLE, clean start held 10 cycles
        add(0,0,0, 1,0,0, 2);
        add(1,1,0, 1,0,0, 6);
        add(1,1,0, 0,1,1, 1);
        add(1,1,0, 0,0,1, 3);
        add(1,0,0, 0,0,1, 8);
        // Stop -> PAUSED
        add(1,1,0, 0,0,1, 6);
        add(1,1,0, 0,1,0, 1);
        add(1,1,0, 0,0,0, 3);
        add(1,0,0, 0,0,0, 8);
        // Clear in PAUSED -> IDLE, no pulse
        add(1,0,1, 0,0,0, 6);
        add(1,0,1, 1,0,0, 4);
        add(1,0,0, 1,0,0, 8);
        // Bounce: highs of 1, 2, 3 cycles split by single lows are discarded
        add(1,1,0, 1,0,0, 1);
        add(1,0,0, 1,0,0, 1);
        add(1,1,0, 1,0,0, 2);
        add(1,0,0, 1,0,0, 1);
        add(1,1,0, 1,0,0, 3);
        add(1,0,0, 1,0,0, 1);
        // then a stable 4-cycle high is accepted
        add(1,1,0, 1,0,0, 4);
        add(1,0,0, 1,0,0, 2);
        add(1,0,0, 0,1,1, 1);
        add(1,0,0, 0,0,1, 8);
        // Clear while RUNNING is ignored
        add(1,0,1, 0,0,1, 10);
        add(1,0,0, 0,0,1, 8);
        // Stop, then both buttons together in PAUSED -> IDLE, no pulse
        add(1,1,0, 0,0,1, 6);
        add(1,1,0, 0,1,0, 1);
        add(1,0,0, 0,0,0, 8);
        add(1,1,1, 0,0,0, 6);
        add(1,1,1, 1,0,0, 3);
        add(1,0,0, 1,0,0, 8);
        // Start, then reset during the pulse cycle
        add(1,1,0, 1,0,0, 6);
        add(1,1,0, 0,1,1, 1);
        add(0,1,0, 1,0,0, 1);
        add(0,0,0, 1,0,0, 1);
        add(1,0,0, 1,0,0, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n           = vecs[i].rst_n;
            bus.i_startstop = vecs[i].ss;
            bus.i_clear     = vecs[i].clr;
            @(posedge clk);
            #1;
            chk("countinit",  i, bus.o_countinit,  vecs[i].init);
            chk("countenb",   i, bus.o_countenb,   vecs[i].enb);
            chk("latchcount", i, bus.o_latchcount, vecs[i].enb);
            chk("running",    i, bus.o_running,    vecs[i].run);
        end

        // Latency from the first edge that samples the press, bounded wait
        bus.i_startstop = 1'b1;
        got = 0;
        lat = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_countenb) begin
                got = 1;
                lat = k;
            end
        end
        chk_int("start_pulse_seen", got, 1);
        chk_int("start_latency", lat, DC + 3);

        // Long hold: no auto-repeat, stays RUNNING
        pulses  = 0;
        latches = 0;
        not_run = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.o_countenb)   pulses++;
            if (bus.o_latchcount) latches++;
            if (!bus.o_running)   not_run++;
        end
        chk_int("hold_no_repeat_enb", pulses, 0);
        chk_int("hold_no_repeat_latch", latches, 0);
        chk_int("hold_stays_running", not_run, 0);
        chk("hold_countinit", 0, bus.o_countinit, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_trigger_ctrl.md
Name: rtc_trigger_ctrl

Overview:
Control front end that sits directly upstream of rtc_counter in the stopwatch. It synchronises and debounces the raw start/stop and clear push-buttons, then runs the stopwatch run/pause/clear state machine. It produces the i_countinit, i_countenb and i_latchcount controls that rtc_counter consumes, plus a running-status level for the LED. All logic runs on the 100 Hz RTC clock.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive rtc clock cycles a synchronised button level must differ from the debounced level before it is accepted; legal range 1..255.

Ports:
i_rtcclk  input  1  RTC clock (10 ms period in hardware); the only clock.
i_reset_n  input  1  reset, synchronous, active-low; sampled on the rising edge of i_rtcclk.
i_startstop  input  1  raw start/stop button, asynchronous, active-high, may bounce.
i_clear  input  1  raw clear button, asynchronous, active-high, may bounce.
o_countinit  output  1  level; high while the stopwatch is cleared (IDLE). Drives rtc_counter i_countinit.
o_countenb  output  1  one-cycle pulse on every accepted start or stop event. Drives rtc_counter i_countenb.
o_latchcount  output  1  one-cycle pulse, coincident with o_countenb. Drives rtc_counter i_latchcount.
o_running  output  1  level; high in RUNNING.

Behaviour:
- Reset (i_reset_n=0 at a rising edge):
  - sync flops, debounced levels and debounce counters go to 0; FSM goes to IDLE.
  - Outputs: o_countinit=1, o_countenb=0, o_latchcount=0, o_running=0.
  - Reset overrides all activity, including mid-debounce and mid-pulse; a pulse in flight is truncated.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce, per button, independently:
  - Counter is $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - While the synchronised level equals the debounced level, the counter is 0.
  - While they differ, the counter increments each cycle.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter returns to 0.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the counter and is discarded.
- Event: a rising edge of a debounced level (previous 0, current 1) is a one-cycle event. Release (falling edge) generates nothing.
- Latency: take the first rising edge at which the raw input is sampled high as edge 1. The registered output responds at rising edge DEBOUNCE_CYCLES+3 (default: edge 7).
- FSM states IDLE, RUNNING, PAUSED; all outputs are registered.
  - IDLE + start/stop event -> RUNNING. Pulse o_countenb and o_latchcount for 1 cycle; o_countinit drops to 0 in the same cycle.
  - RUNNING + start/stop event -> PAUSED. Pulse o_countenb and o_latchcount for 1 cycle.
  - PAUSED + start/stop event -> RUNNING. Pulse o_countenb and o_latchcount for 1 cycle.
  - PAUSED + clear event -> IDLE. o_countinit=1 from the next cycle; no enable pulse.
  - RUNNING + clear event: ignored, no state change.
  - IDLE + clear event: ignored; o_countinit is already 1.
- Simultaneous start/stop and clear events in the same cycle:
  - IDLE or RUNNING: start/stop wins, clear is dropped.
  - PAUSED: clear wins, giving IDLE with no pulse.
- Pulse spacing: back-to-back events cannot occur, because a new press needs a release plus 2*DEBOUNCE_CYCLES. The block is not required to queue events.
- A held button produces exactly one event; auto-repeat is forbidden.
- o_running = (state==RUNNING); o_countinit = (state==IDLE).

Test Plan:
- Reset: hold i_reset_n=0 for 2 cycles with both buttons high -> o_countinit=1, o_countenb=0, o_latchcount=0, o_running=0. After release with buttons still high, one start event fires at edge DEBOUNCE_CYCLES+3 after reset deassertion (edge 7 for the default).
- Clean start: DEBOUNCE_CYCLES=4, raise i_startstop and hold it for 10 cycles -> o_countenb=o_latchcount=1 for exactly 1 cycle, at edge 7. From that cycle o_running=1 and o_countinit=0. Holding the button produces no further pulses.
- Bounce rejection: toggle i_startstop with high runs of 1, 2 and 3 cycles separated by 1-cycle lows -> no pulse and state stays IDLE. A following 4-cycle stable high -> exactly one pulse.
- Full cycle: start, stop, clear, with each button released between presses:
  - after start -> RUNNING;
  - after stop -> PAUSED, o_running=0, second pulse seen;
  - after clear -> o_countinit=1 with no pulse.
  - Total: 2 o_countenb pulses.
- Clear while running: press i_clear in RUNNING -> state unchanged, no pulses, o_countinit stays 0.
- Simultaneous press in PAUSED: assert both buttons on the same edge -> IDLE, o_countinit=1, zero o_countenb pulses.
- Reset mid-operation: assert i_reset_n=0 in RUNNING during the pulse cycle -> next edge gives o_countenb=0 and o_countinit=1.
